// File: rtl/layer_serializer_pkg.sv
// Shared constants and types for the layer-to-layer vector serializer.
// Optional drop counter is enabled with SER_DROP_CNT_EN.
package layer_serializer_pkg;

    localparam int SER_DROP_CNT_W = 16;

    // Beat-index width; never narrower than one bit so NN=1 still has a port.
    function automatic int SER_IDX_W(input int nn);
        return (nn > 1) ? $clog2(nn) : 1;
    endfunction

    typedef enum logic {
        S_IDLE,
        S_SEND
    } ser_state_e;

endpackage

// File: rtl/layer_serializer_if.sv
// Vector-in / beat-out ready-valid bundle of the layer serializer.
interface layer_serializer_if #(
    parameter int NN     = 30,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
);
    logic                 in_valid;
    logic [NN*DATA_W-1:0] in_data;
    logic                 in_ready;
    logic [DATA_W-1:0]    out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [IDX_W-1:0]     out_idx;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_data, out_valid, out_last, out_idx
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_idx
    );
endinterface

// File: rtl/ser_vec_buf.sv
// NN*DATA_W vector register with load, right shift by one neuron and a valid flag.
// OUT_W selects how many low bits are exposed (head only, or the whole vector).
module ser_vec_buf #(
    parameter int NN     = 30,
    parameter int DATA_W = 16,
    parameter int OUT_W  = NN*DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic                 clr,
    input  logic [NN*DATA_W-1:0] load_data,
    output logic [OUT_W-1:0]     data,
    output logic                 vld
);
    logic [NN*DATA_W-1:0] vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            vec <= '0;
            vld <= 1'b0;
        end else begin
            if (load)
                vec <= load_data;
            else if (shift)
                vec <= vec >> DATA_W;
            if (load)
                vld <= 1'b1;
            else if (clr)
                vld <= 1'b0;
        end
    end

    assign data = vec[OUT_W-1:0];
endmodule

// File: rtl/layer_serializer.sv
// Parallel-to-serial stage between NN layers: active + one-deep pending vector,
// ready/valid beat output, overflow pulse. SER_DROP_CNT_EN adds drop_cnt.
module layer_serializer
    import layer_serializer_pkg::*;
#(
    parameter int NN     = 30,
    parameter int DATA_W = 16,
    parameter int IDX_W  = SER_IDX_W(NN)
) (
    input  logic                      clk,
    input  logic                      rst,
    layer_serializer_if.slave         strm,
    output logic                      busy,
`ifdef SER_DROP_CNT_EN
    output logic                      overflow,
    output logic [SER_DROP_CNT_W-1:0] drop_cnt
`else
    output logic                      overflow
`endif
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    ser_state_e           state, state_nxt;
    logic [IDX_W-1:0]     cnt, cnt_nxt;
    logic                 act_load, act_shift, act_clr, pend_load, pend_clr;
    logic [NN*DATA_W-1:0] act_src, pend_data;
    logic [DATA_W-1:0]    act_head;
    logic                 act_vld, pend_vld;
    logic                 sending, last_beat, accept, capture;

    ser_vec_buf #(.NN(NN), .DATA_W(DATA_W), .OUT_W(DATA_W)) u_active (
        .clk(clk), .rst(rst), .load(act_load), .shift(act_shift), .clr(act_clr),
        .load_data(act_src), .data(act_head), .vld(act_vld)
    );

    ser_vec_buf #(.NN(NN), .DATA_W(DATA_W), .OUT_W(NN*DATA_W)) u_pending (
        .clk(clk), .rst(rst), .load(pend_load), .shift(1'b0), .clr(pend_clr),
        .load_data(strm.in_data), .data(pend_data), .vld(pend_vld)
    );

    assign sending   = (state == S_SEND) && act_vld;
    assign last_beat = (cnt == LAST_IDX);
    assign accept    = sending && strm.out_ready;
    // in_ready depends only on registered state; a vector arriving on the
    // final beat while pending is full is dropped rather than chained.
    assign strm.in_ready = ~pend_vld;
    assign capture       = strm.in_valid && !pend_vld;
    assign overflow      = strm.in_valid && pend_vld && !rst;
    assign busy          = sending || pend_vld;

    assign strm.out_valid = sending;
    assign strm.out_data  = sending ? act_head : '0;
    assign strm.out_idx   = sending ? cnt : '0;
    assign strm.out_last  = sending && last_beat;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        act_load  = 1'b0;
        act_shift = 1'b0;
        act_clr   = 1'b0;
        act_src   = strm.in_data;
        pend_load = 1'b0;
        pend_clr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (capture) begin
                    act_load  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (accept && last_beat) begin
                    cnt_nxt = '0;
                    if (pend_vld) begin
                        act_load = 1'b1;
                        act_src  = pend_data;
                        pend_clr = 1'b1;
                    end else if (capture) begin
                        act_load = 1'b1;
                    end else begin
                        act_clr   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    if (accept) begin
                        act_shift = 1'b1;
                        cnt_nxt   = cnt + 1'b1;
                    end
                    if (capture)
                        pend_load = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef SER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else if (overflow && (drop_cnt != '1))
            drop_cnt <= drop_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations (NN=4/DATA_W=8 and NN=1/DATA_W=16).
module tb_layer_serializer;
    localparam int NN = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, overflow, busy1, overflow1;
`ifdef SER_DROP_CNT_EN
    logic [15:0] drop_cnt, drop_cnt1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    layer_serializer_if #(.NN(NN), .DATA_W(DW), .IDX_W(2)) sif ();
    layer_serializer_if #(.NN(1), .DATA_W(16), .IDX_W(1)) sif1 ();

    layer_serializer #(.NN(NN), .DATA_W(DW), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .strm(sif.slave), .busy(busy),
`ifdef SER_DROP_CNT_EN
        .overflow(overflow), .drop_cnt(drop_cnt)
`else
        .overflow(overflow)
`endif
    );

    layer_serializer #(.NN(1), .DATA_W(16), .IDX_W(1)) dut1 (
        .clk(clk), .rst(rst), .strm(sif1.slave), .busy(busy1),
`ifdef SER_DROP_CNT_EN
        .overflow(overflow1), .drop_cnt(drop_cnt1)
`else
        .overflow(overflow1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: list of held vectors (head = streaming) and beats done on head.
    logic [NN*DW-1:0] mq[$];
    int   beat    = 0;
    int   mdrop   = 0;
    bit   started = 0;

    always @(posedge clk) begin
        bit acc, cap, ovf;
        if (rst) begin
            mq.delete();
            beat  = 0;
            mdrop = 0;
        end else begin
            acc = (mq.size() > 0) && sif.out_ready;
            cap = sif.in_valid && (mq.size() < 2);
            ovf = sif.in_valid && (mq.size() >= 2);
            if (ovf && mdrop < 16'hFFFF) mdrop++;
            if (acc) begin
                beat++;
                if (beat == NN) begin
                    void'(mq.pop_front());
                    beat = 0;
                end
            end
            if (cap) mq.push_back(sif.in_data);
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_out_valid", sif.out_valid, mq.size() > 0);
            chk("m_in_ready", sif.in_ready, mq.size() < 2);
            chk("m_busy", busy, mq.size() > 0);
            chk("m_overflow", overflow, sif.in_valid && !rst && (mq.size() >= 2));
            if (mq.size() > 0) begin
                chk("m_out_data", sif.out_data, mq[0][DW*beat +: DW]);
                chk("m_out_idx", sif.out_idx, beat);
                chk("m_out_last", sif.out_last, beat == NN - 1);
            end
`ifdef SER_DROP_CNT_EN
            chk("m_drop_cnt", drop_cnt, mdrop);
`endif
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic rs);
        @(posedge clk);
        #1;
        rst          = rs;
        sif.in_valid = v;
        sif.in_data  = d;
        sif.out_ready = r;
        @(negedge clk);
    endtask

    task automatic reset_dut;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    logic [7:0]  got[$];
    logic [31:0] va, vb, vc;
    int          nvalid;
    logic        pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b1;
        sif1.in_valid = 1'b0; sif1.in_data = '0; sif1.out_ready = 1'b1;
        va = 32'hA4A3A2A1; vb = 32'hB4B3B2B1; vc = 32'hC4C3C2C1;

        // 1: single vector, no backpressure
        reset_dut();
        chk("t1_reset_valid", sif.out_valid, 1'b0);
        chk("t1_reset_in_ready", sif.in_ready, 1'b1);
        step(1'b1, 32'h44332211, 1'b1, 1'b0);
        chk("t1_c0_valid", sif.out_valid, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk("t1_valid", sif.out_valid, 1'b1);
            chk("t1_data", sif.out_data, 8'h11 * i);
            chk("t1_idx", sif.out_idx, i - 1);
            chk("t1_last", sif.out_last, i == 4);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_c5_valid", sif.out_valid, 1'b0);

        // 2: stalls
        reset_dut();
        got.delete();
        step(1'b1, 32'h44332211, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 32'h0, pat[i], 1'b0);
            if (sif.out_valid && sif.out_ready) got.push_back(sif.out_data);
        end
        chk("t2_beats", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) chk("t2_order", got[k], 8'h11 * (k + 1));
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t2_done_valid", sif.out_valid, 1'b0);

        // 3: back-to-back vectors, zero bubble
        reset_dut();
        got.delete();
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            step(i == 0 || i == 2, (i == 0) ? va : vb, 1'b1, 1'b0);
            if (sif.out_valid) got.push_back(sif.out_data);
            if (sif.out_valid && i >= 1 && i <= 8) nvalid++;
            if (i == 3 || i == 4) chk("t3_in_ready_low", sif.in_ready, 1'b0);
        end
        chk("t3_contig", nvalid, 8);
        chk("t3_beats", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk("t3_order", got[k], (k < 4) ? va[8*k +: 8] : vb[8*(k-4) +: 8]);

        // 4: third vector dropped
        reset_dut();
        got.delete();
        for (int i = 0; i < 12; i++) begin
            step(i < 3, (i == 0) ? va : ((i == 1) ? vb : vc), 1'b1, 1'b0);
            if (sif.out_valid) got.push_back(sif.out_data);
            if (i <= 3) chk("t4_overflow", overflow, i == 2);
        end
        chk("t4_beats", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk("t4_order", got[k], (k < 4) ? va[8*k +: 8] : vb[8*(k-4) +: 8]);
`ifdef SER_DROP_CNT_EN
        chk("t4_drop_cnt", drop_cnt, 16'd1);
`endif

        // 5: reset mid-vector with pending held
        reset_dut();
        step(1'b1, va, 1'b1, 1'b0);
        step(1'b1, vb, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t5_valid", sif.out_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_in_ready", sif.in_ready, 1'b1);
        step(1'b1, vc, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t5_new_valid", sif.out_valid, 1'b1);
        chk("t5_new_idx", sif.out_idx, 0);
        chk("t5_new_data", sif.out_data, 8'hC1);

        // 6: NN=1 instance
        reset_dut();
        @(posedge clk); #1;
        sif1.in_valid = 1'b1; sif1.in_data = 16'h0001;
        @(negedge clk);
        chk("t6_c0_valid", sif1.out_valid, 1'b0);
        @(posedge clk); #1;
        sif1.in_data = 16'h0002;
        @(negedge clk);
        chk("t6_c1_valid", sif1.out_valid, 1'b1);
        chk("t6_c1_data", sif1.out_data, 16'h0001);
        chk("t6_c1_last", sif1.out_last, 1'b1);
        chk("t6_c1_idx", sif1.out_idx, 0);
        chk("t6_c1_ovf", overflow1, 1'b0);
        @(posedge clk); #1;
        sif1.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_c2_data", sif1.out_data, 16'h0002);
        chk("t6_c2_last", sif1.out_last, 1'b1);
        chk("t6_c2_idx", sif1.out_idx, 0);
        chk("t6_c2_ovf", overflow1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_c3_valid", sif1.out_valid, 1'b0);

        // Random traffic with backpressure and occasional reset
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 299) == 0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
Parametrised parallel-to-serial stage between NN layers. It captures a full layer output vector of NN neurons × DATA_W bits and emits it one neuron per beat on a ready/valid stream into the next layer's x_in/x_valid.
It is the successor to the per-layer inline serializer FSMs in the top level, with these changes:
- exactly NN beats per vector;
- output backpressure;
- a one-deep pending buffer, so a new vector can land while the previous one drains;
- an explicit overflow indication.

Parameters:
NN, 30, neurons per vector (number of beats); NN >= 1.
DATA_W, 16, bits per neuron value.
IDX_W, $clog2(NN) (min 1), width of beat index.

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  vector valid (layer o_valid[0]); a pulse with no backpressure from the source
in_data  in  NN*DATA_W  vector; neuron k occupies bits [k*DATA_W +: DATA_W]
in_ready  out  1  1 when the pending slot is empty
out_data  out  DATA_W  current neuron value
out_valid  out  1  beat valid
out_ready  in  1  downstream accept; tie to 1 for current layers
out_last  out  1  high with beat NN-1
out_idx  out  IDX_W  neuron index of current beat
busy  out  1  active or pending vector held
overflow  out  1  one-cycle pulse: in_valid seen while in_ready=0; vector dropped

Behaviour:
- Reset values: out_valid, out_last, overflow, busy, in_ready-blocking state, and drop_cnt are all 0. out_data and out_idx are 0. Active and pending buffers are invalidated.
- Reset mid-vector aborts the stream immediately: out_valid=0 on the cycle after rst is sampled.
- Storage:
  - active shift register, NN*DATA_W bits, plus beat counter;
  - pending register, NN*DATA_W bits, plus pend_vld.
- FSM states:
  - IDLE: out_valid=0.
  - SEND: out_valid=1, out_data = active[DATA_W-1:0], out_idx = counter, out_last = (counter == NN-1).
- Beat accepted = out_valid & out_ready. On accept: shift active right by DATA_W, counter+1.
- Hold rule: while out_valid=1 and out_ready=0, out_data, out_idx and out_last stay stable.
- Capture = in_valid & in_ready. Destination of a captured vector:
  - IDLE → active directly. SEND next cycle, so first beat is valid 1 cycle after in_valid (latency 1).
  - SEND, not (last beat accepted this cycle), pend_vld=0 → pending.
  - SEND, last beat accepted this cycle, pend_vld=0 → active directly; stays SEND with counter=0 (zero bubble).
- End of vector (last beat accepted):
  - pend_vld=1 → pending moves to active, pend_vld cleared, counter=0, stays SEND (zero bubble).
  - otherwise, if no simultaneous capture → IDLE.
- in_ready = ~pend_vld, registered-state based with no combinational path from out_ready.
  - In the last-beat + pend_vld=1 cycle, in_ready is still 0. A vector arriving then is dropped and flagged (conservative, by design).
- Overflow: in_valid & ~in_ready → overflow=1 for one cycle. The incoming vector is discarded; active and pending contents are unaffected.
- Vector order out equals capture order. No beats are reordered or duplicated. Exactly NN accepts per vector.
- NN=1: every beat has out_last=1 and out_idx=0.
- busy = (state==SEND) | pend_vld.

Optional Feature:
Macro SER_DROP_CNT_EN.
- Defined: extra output port drop_cnt [15:0]. It increments on every overflow pulse, saturates at 16'hFFFF, and clears only on rst. Read through the AXI-Lite register block for debug.
- Undefined: no port and no counter. The overflow pulse is still present.

Decomposition:
- Shared package/include gains the constants SER_IDX_W(NN) and SER_DROP_CNT_W=16.
- Layer widths (numNeuronLayerN, dataWidth) continue to come from the existing global include.
- One natural sub-module: ser_vec_buf. It holds the NN*DATA_W register, load/shift/valid, and is instantiated twice (active, pending).
- The FSM and counters stay in layer_serializer.
- The top level replaces its three inline serializer FSMs with three instances. Layer k+1 then uses x_valid=out_valid and x_in=out_data, with out_ready=1.

Test Plan:
1. NN=4, DATA_W=8, out_ready=1; in_data=32'h44332211 pulsed at cycle 0 → beats 11,22,33,44 at cycles 1–4; out_idx 0..3; out_last only at cycle 4; out_valid=0 at cycle 5.
2. Same vector, out_ready toggled 1,0,0,1,1,0,1 → exactly 4 accepted beats in order 11,22,33,44; out_data/out_idx stable during stalls.
3. Vector A=32'hA4A3A2A1 at cycle 0, B=32'hB4B3B2B1 at cycle 2, out_ready=1 → 8 contiguous beats A1..A4,B1..B4 with no bubble; in_ready=0 during cycles 3–4.
4. A at cycle 0, B at cycle 1, C at cycle 2 → C dropped; overflow=1 at cycle 2 only; output A then B only; with SER_DROP_CNT_EN, drop_cnt=1.
5. rst asserted at cycle 2 mid-vector with pending valid → out_valid=0, busy=0, in_ready=1 from cycle 3; a new vector afterwards streams from idx 0.
6. NN=1, DATA_W=16, vectors 16'h0001 and 16'h0002 on consecutive cycles → two beats, each out_last=1, out_idx=0, no overflow.
